// File: rtl/pipe_pkg.sv
// Shared types for the pipeline hazard controller: the per-stage tag carried
// alongside each instruction and the forward-select encoding.
package pipe_pkg;

    localparam int MAX_REG_AW = 8;

    // Forward select 0 means "use the register file"; k selects the result held in P(k).
    localparam int FWD_RF = 0;

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    typedef logic [MAX_REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rd;
        logic      regwrite;
        logic      memread;
        reg_addr_t rs;
        reg_addr_t rt;
        logic      rs_used;
        logic      rt_used;
    } pipe_tag_t;

    localparam pipe_tag_t TAG_NONE = '0;

    function automatic int fwd_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Register 0 is hard-wired, so a write to it never produces a value.
    function automatic logic is_producer(input pipe_tag_t t);
        return t.valid && t.regwrite && (t.rd != '0);
    endfunction

endpackage

// File: rtl/pipe_fwd_select.sv
// Finds the newest producer among a run of pipe stages that writes a given
// source register; reports its stage number and whether it is a load.
module pipe_fwd_select
    import pipe_pkg::*;
#(
    parameter int N     = 2,
    parameter int SEL_W = 2,
    parameter int BASE  = 2
) (
    input  reg_addr_t              src_i,
    input  logic                   src_used_i,
    input  reg_addr_t [N-1:0]      prod_rd_i,
    input  logic      [N-1:0]      prod_vld_i,
    input  logic      [N-1:0]      prod_load_i,
    output logic      [SEL_W-1:0]  sel_o,
    output logic                   load_o
);

    always_comb begin
        // NOTE: every output gets a default before any conditional write, so no latch is inferred.
        sel_o  = '0;
        load_o = 1'b0;
        // Walk oldest to youngest so the youngest match is the one left standing.
        for (int i = N - 1; i >= 0; i--) begin
            if (src_used_i && prod_vld_i[i] && (prod_rd_i[i] == src_i)) begin
                sel_o  = SEL_W'(i + BASE);
                load_o = prod_load_i[i];
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard unit for an in-order pipeline: tracks instruction tags through the
// pipe registers, selects forwarding paths, and raises load-use stalls and branch flushes.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int REG_AW        = 5,
    parameter int DEPTH         = 3,
    parameter int LOAD_STAGE    = 2,
    parameter int RESOLVE_STAGE = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         id_valid_i,
    input  logic [REG_AW-1:0]            id_rs_i,
    input  logic [REG_AW-1:0]            id_rt_i,
    input  logic                         id_rs_used_i,
    input  logic                         id_rt_used_i,
    input  logic [REG_AW-1:0]            id_rd_i,
    input  logic                         id_regwrite_i,
    input  logic                         id_memread_i,
    input  logic                         branch_taken_i,
    output logic                         pc_write_o,
    output logic                         ifid_write_o,
    output logic                         if_flush_o,
    output logic                         id_flush_o,
    output logic [DEPTH-1:0]             stage_kill_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_a_o,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_b_o,
    output logic                         id_byp_a_o,
    output logic                         id_byp_b_o,
    output logic [15:0]                  stall_cnt_o,
    output logic [15:0]                  flush_cnt_o
);

    if (REG_AW < 1 || REG_AW > MAX_REG_AW) begin : g_bad_reg_aw
        $fatal(1, "pipe_hazard_ctrl: REG_AW out of range");
    end
    if (DEPTH < 2) begin : g_bad_depth
        $fatal(1, "pipe_hazard_ctrl: DEPTH must be at least 2");
    end
    if (LOAD_STAGE < 1 || LOAD_STAGE >= DEPTH) begin : g_bad_load_stage
        $fatal(1, "pipe_hazard_ctrl: LOAD_STAGE out of range");
    end
    if (RESOLVE_STAGE < 1 || RESOLVE_STAGE > DEPTH) begin : g_bad_resolve_stage
        $fatal(1, "pipe_hazard_ctrl: RESOLVE_STAGE out of range");
    end

    localparam int                SEL_W      = fwd_width(DEPTH);
    localparam logic [SEL_W-1:0]  LOAD_SEL   = SEL_W'(LOAD_STAGE);
    localparam logic [SEL_W-1:0]  FWD_RF_SEL = SEL_W'(FWD_RF);
    localparam logic [DEPTH-1:0]  KILL_MASK  = DEPTH'((1 << (RESOLVE_STAGE - 1)) - 1);

    // Index k holds the tag of pipe register P(k+1).
    pipe_tag_t tag_q [DEPTH];
    pipe_tag_t tag_d [DEPTH];
    pipe_tag_t id_tag;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    reg_addr_t id_rs, id_rt;
    logic [DEPTH-1:0] hit_rs, hit_rt;
    logic [DEPTH-2:0] stage_load;
    logic flush, stall;

    reg_addr_t [DEPTH-2:0] prod_rd;
    logic      [DEPTH-2:0] prod_vld, prod_load;
    logic      [SEL_W-1:0] sel_a, sel_b;
    logic                  load_a, load_b;

    assign id_rs = reg_addr_t'(id_rs_i);
    assign id_rt = reg_addr_t'(id_rt_i);

    // Only the newest match decides: a younger non-load hides an older load.
    function automatic logic early_load(input logic [DEPTH-2:0] hit, input logic [DEPTH-2:0] is_load);
        logic found, res;
        found = 1'b0;
        res   = 1'b0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            if (hit[k] && !found) begin
                found = 1'b1;
                res   = is_load[k] && (k < LOAD_STAGE - 1);
            end
        end
        return res;
    endfunction

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            hit_rs[k] = id_rs_used_i && is_producer(tag_q[k]) && (tag_q[k].rd == id_rs);
            hit_rt[k] = id_rt_used_i && is_producer(tag_q[k]) && (tag_q[k].rd == id_rt);
        end
        for (int k = 0; k < DEPTH - 1; k++) begin
            stage_load[k] = tag_q[k].memread;
            prod_rd[k]    = tag_q[k+1].rd;
            prod_vld[k]   = is_producer(tag_q[k+1]);
            prod_load[k]  = tag_q[k+1].memread;
        end
    end

    assign flush = branch_taken_i && !rst_i;
    assign stall = !rst_i && !branch_taken_i && id_valid_i &&
                   (early_load(hit_rs[DEPTH-2:0], stage_load) ||
                    early_load(hit_rt[DEPTH-2:0], stage_load));

    pipe_fwd_select #(.N(DEPTH - 1), .SEL_W(SEL_W), .BASE(2)) u_fwd_a (
        .src_i       (tag_q[0].rs),
        .src_used_i  (tag_q[0].valid && tag_q[0].rs_used),
        .prod_rd_i   (prod_rd),
        .prod_vld_i  (prod_vld),
        .prod_load_i (prod_load),
        .sel_o       (sel_a),
        .load_o      (load_a)
    );

    pipe_fwd_select #(.N(DEPTH - 1), .SEL_W(SEL_W), .BASE(2)) u_fwd_b (
        .src_i       (tag_q[0].rt),
        .src_used_i  (tag_q[0].valid && tag_q[0].rt_used),
        .prod_rd_i   (prod_rd),
        .prod_vld_i  (prod_vld),
        .prod_load_i (prod_load),
        .sel_o       (sel_b),
        .load_o      (load_b)
    );

    always_comb begin
        id_tag = TAG_NONE;
        if (id_valid_i && !stall && !branch_taken_i) begin
            id_tag.valid    = 1'b1;
            id_tag.rd       = reg_addr_t'(id_rd_i);
            id_tag.regwrite = id_regwrite_i;
            id_tag.memread  = id_memread_i;
            id_tag.rs       = id_rs;
            id_tag.rt       = id_rt;
            id_tag.rs_used  = id_rs_used_i;
            id_tag.rt_used  = id_rt_used_i;
        end
        tag_d[0] = id_tag;
        // A taken branch squashes everything younger than itself; the branch moves on.
        for (int k = 1; k < DEPTH; k++) begin
            tag_d[k] = (branch_taken_i && (k < RESOLVE_STAGE)) ? TAG_NONE : tag_q[k-1];
        end
        stall_cnt_d = stall_cnt_q + ((stall && stall_cnt_q != CNT_MAX) ? 16'd1 : 16'd0);
        flush_cnt_d = flush_cnt_q + ((flush && flush_cnt_q != CNT_MAX) ? 16'd1 : 16'd0);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: the tag array is reset because stale valid bits would fake hazards after reset.
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= TAG_NONE;
            end
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every stage shifting off the same old values.
            for (int k = 0; k < DEPTH; k++) begin
                tag_q[k] <= tag_d[k];
            end
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    always_comb begin
        pc_write_o   = !stall;
        ifid_write_o = !stall;
        if_flush_o   = flush;
        id_flush_o   = flush;
        stage_kill_o = '0;
        if (flush) begin
            stage_kill_o = KILL_MASK;
        end else if (stall) begin
            stage_kill_o[0] = 1'b1;
        end
        // A load still too young to forward yields the register file select.
        fwd_a_o    = (rst_i || (load_a && sel_a <= LOAD_SEL)) ? FWD_RF_SEL : sel_a;
        fwd_b_o    = (rst_i || (load_b && sel_b <= LOAD_SEL)) ? FWD_RF_SEL : sel_b;
        id_byp_a_o = !rst_i && hit_rs[DEPTH-1] && !(|hit_rs[DEPTH-2:0]);
        id_byp_b_o = !rst_i && hit_rt[DEPTH-1] && !(|hit_rt[DEPTH-2:0]);
        stall_cnt_o = stall_cnt_q;
        flush_cnt_o = flush_cnt_q;
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios, randomized
// traffic against a rule-level model, and counter saturation on a deep variant.
module tb_pipe_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default-parameter DUT
    logic       rst, id_valid, id_rs_used, id_rt_used, id_regwrite, id_memread, branch;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       pc_write, ifid_write, if_flush, id_flush, byp_a, byp_b;
    logic [2:0] stage_kill;
    logic [1:0] fwd_a, fwd_b;
    logic [15:0] stall_cnt, flush_cnt;

    pipe_hazard_ctrl dut (
        .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid),
        .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rs_used_i(id_rs_used), .id_rt_used_i(id_rt_used),
        .id_rd_i(id_rd), .id_regwrite_i(id_regwrite), .id_memread_i(id_memread),
        .branch_taken_i(branch), .pc_write_o(pc_write), .ifid_write_o(ifid_write),
        .if_flush_o(if_flush), .id_flush_o(id_flush), .stage_kill_o(stage_kill),
        .fwd_a_o(fwd_a), .fwd_b_o(fwd_b), .id_byp_a_o(byp_a), .id_byp_b_o(byp_b),
        .stall_cnt_o(stall_cnt), .flush_cnt_o(flush_cnt)
    );

    wire [12:0] ctl = {pc_write, ifid_write, if_flush, id_flush, stage_kill, fwd_a, fwd_b, byp_a, byp_b};

    // Deep variant where a load stalls for many cycles, used to reach counter saturation
    logic        s_rst, s_valid, s_branch;
    logic [4:0]  s_reg;
    logic        s_pc_write, s_ifid_write, s_if_flush, s_id_flush, s_byp_a, s_byp_b;
    logic [15:0] s_kill;
    logic [4:0]  s_fwd_a, s_fwd_b;
    logic [15:0] s_stall_cnt, s_flush_cnt;

    pipe_hazard_ctrl #(.REG_AW(5), .DEPTH(16), .LOAD_STAGE(15), .RESOLVE_STAGE(2)) dut_sat (
        .clk_i(clk), .rst_i(s_rst), .id_valid_i(s_valid),
        .id_rs_i(s_reg), .id_rt_i(s_reg), .id_rs_used_i(s_valid), .id_rt_used_i(1'b0),
        .id_rd_i(s_reg), .id_regwrite_i(s_valid), .id_memread_i(s_valid),
        .branch_taken_i(s_branch), .pc_write_o(s_pc_write), .ifid_write_o(s_ifid_write),
        .if_flush_o(s_if_flush), .id_flush_o(s_id_flush), .stage_kill_o(s_kill),
        .fwd_a_o(s_fwd_a), .fwd_b_o(s_fwd_b), .id_byp_a_o(s_byp_a), .id_byp_b_o(s_byp_b),
        .stall_cnt_o(s_stall_cnt), .flush_cnt_o(s_flush_cnt)
    );

    localparam logic [12:0] CTL_IDLE = {1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 2'd0, 2'd0, 1'b0, 1'b0};

    function automatic logic [12:0] exp_ctl(input bit pc, input bit fl, input logic [2:0] kill,
                                            input int fa, input int fb, input bit ba, input bit bb);
        return {pc, pc, fl, fl, kill, 2'(fa), 2'(fb), ba, bb};
    endfunction

    // Instruction model: one entry per pipe register P1..P3
    typedef struct {
        bit valid; int rd; bit rw; bit ld; int rs; int rt; bit rsu; bit rtu;
    } minst_t;

    minst_t m [1:3];
    int m_stalls, m_flushes;

    function automatic bit writes(input int k, input int r);
        return m[k].valid && m[k].rw && (m[k].rd != 0) && (m[k].rd == r);
    endfunction

    function automatic int newest(input int r, input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (writes(k, r)) return k;
        return 0;
    endfunction

    function automatic int m_fwd(input int r, input bit used);
        int k;
        if (rst || !m[1].valid || !used) return 0;
        k = newest(r, 2, 3);
        if (k != 0 && m[k].ld && k <= 2) return 0;
        return k;
    endfunction

    function automatic bit m_load_use(input int r, input bit used);
        int k;
        if (!used) return 0;
        k = newest(r, 1, 2);
        return (k == 1) && m[1].ld;
    endfunction

    function automatic bit m_byp(input int r, input bit used);
        return !rst && used && newest(r, 1, 2) == 0 && writes(3, r);
    endfunction

    task automatic model_clear();
        for (int k = 1; k <= 3; k++) m[k] = '{default: 0};
        m_stalls = 0;
        m_flushes = 0;
    endtask

    task automatic model_advance(input bit st);
        minst_t none, nw;
        none = '{default: 0};
        nw   = '{valid: 1, rd: int'(id_rd), rw: id_regwrite, ld: id_memread, rs: int'(id_rs),
                 rt: int'(id_rt), rsu: id_rs_used, rtu: id_rt_used};
        if (rst) begin
            model_clear();
        end else begin
            m[3] = m[2];
            m[2] = branch ? none : m[1];
            m[1] = (id_valid && !st && !branch) ? nw : none;
            if (st && m_stalls < 65535) m_stalls++;
            if (branch && m_flushes < 65535) m_flushes++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input bit v, input int rd, input bit rw, input bit ld,
                            input int rs, input bit rsu, input int rt, input bit rtu);
        id_valid = v; id_rd = 5'(rd); id_regwrite = rw; id_memread = ld;
        id_rs = 5'(rs); id_rs_used = rsu; id_rt = 5'(rt); id_rt_used = rtu;
    endtask

    task automatic id_idle();
        drive_id(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1; branch = 1'b0; id_idle();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; branch = 1'b1;
        drive_id(1, 4, 1, 0, 3, 1, 3, 1);
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL reset_ctl_during: got %h want %h", ctl, CTL_IDLE); end
        tick();
        @(negedge clk);
        checks++;
        if ({stall_cnt, flush_cnt} !== 32'h0) begin
            failures++; $display("FAIL reset_counters: got %h/%h want 0/0", stall_cnt, flush_cnt);
        end
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL reset_ctl_held: got %h want %h", ctl, CTL_IDLE); end
        tick();
        rst = 1'b0; branch = 1'b0; id_idle();
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL reset_ctl_after: got %h want %h", ctl, CTL_IDLE); end
        tick();
    endtask

    task automatic test_chain();
        do_reset();
        drive_id(1, 1, 1, 0, 6, 0, 7, 0);     // add r1
        tick();
        drive_id(1, 2, 1, 0, 1, 1, 0, 0);     // sub r2, r1
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL chain_no_stall: got %h want %h", ctl, CTL_IDLE); end
        tick();
        id_idle();
        @(negedge clk);
        checks++;
        if (ctl !== exp_ctl(1, 0, 3'b000, 2, 0, 0, 0)) begin
            failures++; $display("FAIL chain_fwd: got %h want %h", ctl, exp_ctl(1, 0, 3'b000, 2, 0, 0, 0));
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        drive_id(1, 3, 1, 1, 0, 0, 0, 0);     // lw r3
        tick();
        drive_id(1, 4, 1, 0, 3, 1, 0, 0);     // add r4, r3
        @(negedge clk);
        checks++;
        if (ctl !== exp_ctl(0, 0, 3'b001, 0, 0, 0, 0)) begin
            failures++; $display("FAIL load_use_stall: got %h want %h", ctl, exp_ctl(0, 0, 3'b001, 0, 0, 0, 0));
        end
        tick();
        checks++;
        if (stall_cnt !== 16'd1) begin failures++; $display("FAIL load_use_cnt: got %0d want 1", stall_cnt); end
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL load_use_release: got %h want %h", ctl, CTL_IDLE); end
        tick();
        drive_id(1, 7, 1, 0, 3, 1, 0, 0);     // or r7, r3 while lw sits in P3
        @(negedge clk);
        checks++;
        if (ctl !== exp_ctl(1, 0, 3'b000, 3, 0, 1, 0)) begin
            failures++; $display("FAIL load_use_fwd3_byp: got %h want %h", ctl, exp_ctl(1, 0, 3'b000, 3, 0, 1, 0));
        end
        checks++;
        if (stall_cnt !== 16'd1) begin failures++; $display("FAIL load_use_cnt_hold: got %0d want 1", stall_cnt); end
        tick();
    endtask

    task automatic test_newest_wins();
        do_reset();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        drive_id(1, 5, 1, 0, 0, 0, 0, 0);
        tick();
        drive_id(1, 6, 1, 0, 5, 1, 5, 1);
        tick();
        id_idle();
        @(negedge clk);
        checks++;
        if (ctl !== exp_ctl(1, 0, 3'b000, 2, 2, 0, 0)) begin
            failures++; $display("FAIL newest_wins: got %h want %h", ctl, exp_ctl(1, 0, 3'b000, 2, 2, 0, 0));
        end
        tick();
    endtask

    task automatic test_flush();
        do_reset();
        drive_id(1, 3, 1, 1, 0, 0, 0, 0);     // lw r3
        tick();
        drive_id(1, 4, 1, 0, 3, 1, 0, 0);     // load-use in ID
        branch = 1'b1;
        @(negedge clk);
        checks++;
        if (ctl !== exp_ctl(1, 1, 3'b001, 0, 0, 0, 0)) begin
            failures++; $display("FAIL flush_ctl: got %h want %h", ctl, exp_ctl(1, 1, 3'b001, 0, 0, 0, 0));
        end
        tick();
        branch = 1'b0;
        checks++;
        if ({stall_cnt, flush_cnt} !== {16'd0, 16'd1}) begin
            failures++; $display("FAIL flush_counters: got %0d/%0d want 0/1", stall_cnt, flush_cnt);
        end
        // The squashed load must no longer cause a stall
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL flush_squashed: got %h want %h", ctl, CTL_IDLE); end
        tick();
        id_idle();
    endtask

    task automatic test_r0_and_invalid();
        do_reset();
        drive_id(1, 0, 1, 1, 0, 0, 0, 0);     // lw r0
        tick();
        drive_id(1, 2, 1, 0, 0, 1, 0, 1);     // uses r0
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL r0_no_stall: got %h want %h", ctl, CTL_IDLE); end
        tick();
        drive_id(1, 3, 1, 1, 0, 0, 0, 0);     // lw r3
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL r0_no_fwd: got %h want %h", ctl, CTL_IDLE); end
        tick();
        drive_id(0, 4, 1, 0, 3, 1, 3, 1);     // invalid slot naming r3
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL invalid_no_stall: got %h want %h", ctl, CTL_IDLE); end
        tick();
        id_idle();
        checks++;
        if (stall_cnt !== 16'd0) begin failures++; $display("FAIL r0_invalid_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        drive_id(1, 3, 1, 1, 0, 0, 0, 0);
        tick();
        drive_id(1, 4, 1, 0, 3, 1, 0, 0);
        tick();                                // first stall taken
        drive_id(1, 3, 1, 1, 0, 0, 0, 0);
        tick();
        drive_id(1, 4, 1, 0, 3, 1, 0, 0);
        rst = 1'b1;                            // reset lands on a stall cycle
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL mid_stall_during: got %h want %h", ctl, CTL_IDLE); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ctl !== CTL_IDLE) begin failures++; $display("FAIL mid_stall_after: got %h want %h", ctl, CTL_IDLE); end
        checks++;
        if ({stall_cnt, flush_cnt} !== 32'h0) begin
            failures++; $display("FAIL mid_stall_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt);
        end
        tick();
        id_idle();
    endtask

    task automatic test_random();
        bit st;
        logic [2:0] kill;
        logic [12:0] e;
        do_reset();
        model_clear();
        for (int n = 0; n < 400; n++) begin
            rst    = ($urandom_range(0, 49) == 0);
            branch = ($urandom_range(0, 9) == 0);
            drive_id($urandom_range(0, 4) != 0, $urandom_range(0, 3), $urandom_range(0, 9) < 7,
                     $urandom_range(0, 9) < 3, $urandom_range(0, 3), $urandom_range(0, 9) < 7,
                     $urandom_range(0, 3), $urandom_range(0, 9) < 7);
            st = !rst && !branch && id_valid &&
                 (m_load_use(int'(id_rs), id_rs_used) || m_load_use(int'(id_rt), id_rt_used));
            kill = rst ? 3'b000 : (branch || st) ? 3'b001 : 3'b000;
            e = exp_ctl(!st, branch && !rst, kill, m_fwd(m[1].rs, m[1].rsu), m_fwd(m[1].rt, m[1].rtu),
                        m_byp(int'(id_rs), id_rs_used), m_byp(int'(id_rt), id_rt_used));
            @(negedge clk);
            checks++;
            if (ctl !== e) begin failures++; $display("FAIL random_ctl[%0d]: got %h want %h", n, ctl, e); end
            tick();
            model_advance(st);
            checks++;
            if (stall_cnt !== 16'(m_stalls) || flush_cnt !== 16'(m_flushes)) begin
                failures++;
                $display("FAIL random_cnt[%0d]: got %0d/%0d want %0d/%0d", n, stall_cnt, flush_cnt, m_stalls, m_flushes);
            end
        end
        rst = 1'b0; branch = 1'b0; id_idle();
    endtask

    // One load repeatedly entering: it stalls while in P1..P14 and lets the next load in at P15,
    // giving 14 stalls in every 15 cycles.
    task automatic test_saturation();
        s_rst = 1'b1; s_valid = 1'b1; s_branch = 1'b0; s_reg = 5'd3;
        tick();
        s_rst = 1'b0;
        repeat (150) tick();
        checks++;
        if (s_stall_cnt !== 16'd140) begin failures++; $display("FAIL sat_partial: got %0d want 140", s_stall_cnt); end
        repeat (71850) tick();
        checks++;
        if (s_stall_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_full: got %h want ffff", s_stall_cnt); end
        repeat (20) tick();
        checks++;
        if ({s_stall_cnt, s_flush_cnt} !== {16'hFFFF, 16'h0}) begin
            failures++; $display("FAIL sat_hold: got %h/%h want ffff/0000", s_stall_cnt, s_flush_cnt);
        end
    endtask

    initial begin
        rst = 1'b1; branch = 1'b0; id_idle();
        s_rst = 1'b1; s_valid = 1'b0; s_branch = 1'b0; s_reg = 5'd0;
        test_reset();
        test_chain();
        test_load_use();
        test_newest_wins();
        test_flush();
        test_r0_and_invalid();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter REG_AW, default 5: register-address width.
REQ-002 Parameter DEPTH, default 3: tracked pipe registers P1..PDEPTH (P1=ID/EX, P2=EX/MEM, P3=MEM/WB).
REQ-003 Parameter LOAD_STAGE, default 2: load data first forwardable from P(LOAD_STAGE+1); legal range 1 <= LOAD_STAGE < DEPTH.
REQ-004 Parameter RESOLVE_STAGE, default 2: branch resolves while in P(RESOLVE_STAGE); legal range 1..DEPTH.
REQ-005 Ports: clk_i in 1 clock; rst_i in 1 reset. One clock; reset is synchronous and active-high.
REQ-006 id_valid_i in 1, ID holds a real instruction.
REQ-007 id_rs_i, id_rt_i in REG_AW, ID source registers; id_rs_used_i, id_rt_used_i in 1 each.
REQ-008 id_rd_i in REG_AW, id_regwrite_i in 1, id_memread_i in 1: ID destination and type.
REQ-009 branch_taken_i in 1, taken branch in P(RESOLVE_STAGE).
REQ-010 pc_write_o out 1; ifid_write_o out 1; if_flush_o out 1; id_flush_o out 1.
REQ-011 stage_kill_o out DEPTH, bit k-1 zeroes control of the P(k) instruction as it advances.
REQ-012 fwd_a_o, fwd_b_o out clog2(DEPTH+1): 0 = register file, k = result held in P(k).
REQ-013 id_byp_a_o, id_byp_b_o out 1: ID operand takes write-back data from P(DEPTH).
REQ-014 stall_cnt_o, flush_cnt_o out 16, saturating event counters.

Function
REQ-015 Per Pk, the block SHALL hold a tag {valid, rd, regwrite, memread, rs, rt, rs_used, rt_used} that shifts Pk->Pk+1 every clock; the P(DEPTH) tag is discarded.
REQ-016 A producer SHALL be a valid tag with regwrite=1 and rd!=0; register 0 never matches.
REQ-017 For each used P1 source, fwd_x_o SHALL equal the smallest k in 2..DEPTH whose producer rd matches, else 0, combinationally.
REQ-018 If that newest match is a load at k <= LOAD_STAGE, fwd_x_o SHALL be 0; this case is a protocol violation.
REQ-019 Load-use stall: id_valid_i=1, a used ID source's newest matching producer in P1..P(DEPTH-1) is a load at Pk, k <= LOAD_STAGE-1 -> stall.
REQ-020 Stall: pc_write_o=0, ifid_write_o=0, bubble (valid=0) enters P1, stage_kill_o[0]=1, older tags shift normally.
REQ-021 id_byp_x_o=1 SHALL hold when a used ID source matches the P(DEPTH) producer and no younger producer P1..P(DEPTH-1) matches.
REQ-022 Flush on branch_taken_i=1: if_flush_o=1, id_flush_o=1, stage_kill_o bits 0..RESOLVE_STAGE-2 =1, pc_write_o=1.
REQ-023 Flush: tags entering P1..P(RESOLVE_STAGE) SHALL become invalid; P(RESOLVE_STAGE) tag advances unchanged.
REQ-024 Flush and stall together: flush SHALL win; no stall; only flush_cnt_o increments.
REQ-025 Idle: pc_write_o=1, ifid_write_o=1, flushes 0, stage_kill_o=0.
REQ-026 Each stall cycle SHALL increment stall_cnt_o and each flush cycle flush_cnt_o, holding at 16'hFFFF.
REQ-027 id_valid_i=0 SHALL insert an invalid tag and never cause a stall.

Reset
REQ-028 rst_i=1 at a clock edge SHALL clear all tags and both counters, overriding flush and stall.
REQ-029 During and after reset: pc_write_o=1, ifid_write_o=1, if_flush_o=0, id_flush_o=0, stage_kill_o=0, fwd=0, id_byp=0.

Structure
REQ-030 The package pipe_pkg SHALL hold the tag struct and the forward-select encoding constants.
REQ-031 Sub-module pipe_fwd_select SHALL compute one fwd select plus its newest-match load flag; instantiate twice.
REQ-032 Parameter legality SHALL be checked at elaboration; illegal values stop elaboration.

Verification
REQ-033 Chain: add r1 -> sub r2,r1 -> fwd_a_o=2, no stall.
REQ-034 lw r3 -> add r4,r3: one stall, stall_cnt_o=1, then fwd_a_o=3.
REQ-035 add r5 in P2, add r5 in P3, src r5 -> fwd_a_o=2 (newest wins).
REQ-036 branch_taken_i with P1 valid, ID in load-use -> if_flush/id_flush/stage_kill_o=3'b001, no stall, flush_cnt_o=1.
REQ-037 Writes to r0 and id_valid_i=0 -> fwd 0, no stall.
REQ-038 Reset mid-stall -> all outputs at reset values next cycle; 70000 stalls -> stall_cnt_o=16'hFFFF.
